resample_phase_scheduler: RTL and testbench
===========================================

// Module: resample_phase_scheduler
// PURPOSE
// Sequencer for the L/M polyphase resampling datapath (input buffer -> accumulate_multiply).
// Walks the streams round-robin. For each stream's next output sample it issues the polyphase
// coefficient phase to the MAC, then issues the required number of input-advance commands to the buffer.
// Per-stream phase state is held locally, so each stream resamples independently.
// PARAMETERS
// L               160  upsampling factor; phase range 0..L-1
// L_LOG           8    width of phase index; L <= 2^L_LOG
// M               147  downsampling factor; M < 2^M_LOG; M > L is legal
// M_LOG           8    width to hold M
// NR_STREAMS      16   number of interleaved streams
// NR_STREAMS_LOG  4    width of stream index; NR_STREAMS <= 2^NR_STREAMS_LOG
// PORTS
// clk        in   1               clock, rising edge
// rst        in   1               asynchronous, active-low reset (0 = reset)
// en         in   1               run enable; sampled only in IDLE and NEXT
// ph_req     out  1               phase command request (4-phase handshake)
// ph_ack     in   1               phase command acknowledge from MAC
// ph_stream  out  [0:NR_STREAMS_LOG-1]  stream of phase command
// ph_index   out  [0:L_LOG-1]     coefficient phase for this output sample
// adv_req    out  1               input-advance request (4-phase handshake)
// adv_ack    in   1               acknowledge: one input sample consumed by buffer
// adv_stream out  [0:NR_STREAMS_LOG-1]  stream to advance
// busy       out  1               high whenever state != IDLE
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; all outputs 0; stream ptr s=0; phase[0..NR_STREAMS-1]=0; acc=0.
// - Handshake, both channels, 4-phase: req rises with data stable -> wait ack=1 -> req falls -> wait ack=0.
//   Data is held from req rise until ack falls. req is a registered decode of state.
// - acc width L_LOG+M_LOG+1 bits, unsigned; no truncation.
// - FSM:
//   IDLE:    en=1 -> LOAD.
//   LOAD:    ph_index<=phase[s], ph_stream<=s, adv_stream<=s, acc<=phase[s]+M; -> PH_REQ.
//   PH_REQ:  ph_req=1; ph_ack=1 -> PH_REL.
//   PH_REL:  ph_req=0; ph_ack=0 -> ADV_CHK.
//   ADV_CHK: acc>=L -> ADV_REQ, else -> NEXT.
//   ADV_REQ: adv_req=1; adv_ack=1 -> ADV_REL.
//   ADV_REL: adv_req=0; adv_ack=0 -> acc<=acc-L, -> ADV_CHK.
//   NEXT:    phase[s]<=acc (now <L); s<=(s==NR_STREAMS-1)?0:s+1; en=1 -> LOAD, else -> IDLE.
// - Net effect per output: phase p, then floor((p+M)/L) advance handshakes; new phase (p+M) mod L.
// - Latency: en sampled high in IDLE at edge k -> ph_req high after edge k+2.
// - en low mid-sequence never aborts: the current output's phase and all its advance handshakes
//   complete, then IDLE. Resume continues at the next stream with stored phases intact.
// - ack held high out of turn (ph_ack in LOAD, adv_ack in ADV_CHK) is ignored until the matching req state.
// - Reset mid-handshake: req drops immediately. After release, restart from stream 0, phase 0.
//   The partner must be reset together with this block.
// - busy=0 only in IDLE.
// TESTING
// 1. Hold rst=0, toggle clk -> ph_req=adv_req=busy=0, ph_index=0, ph_stream=0; release rst, en=0 -> stays IDLE.
// 2. NR_STREAMS=1, L=160, M=147, zero-delay ack responders, en=1 -> ph_index 0,147,134,121...;
//    advances per output 0,1,1,...; after 160 outputs: 147 advances, phase back to 0.
// 3. NR_STREAMS=4 -> ph_stream 0,1,2,3,0,...; ph_index 0,0,0,0,147,147,147,147,134...; adv_stream = ph_stream.
// 4. L=3, M=7 -> ph_index 0,1,2,0; advances per output 2,2,3 (sum 7 per 3 outputs).
// 5. en dropped while ph_ack held low for 10 cycles -> ph handshake completes, 1 advance (phase 147 case),
//    IDLE, busy=0; en=1 -> next stream, phase unchanged.
// 6. rst=0 asserted while adv_req=1 -> adv_req=0 same cycle (async); after release + en -> stream 0, ph_index 0.

Source files
------------

// File: rtl/resample_phase_scheduler_if.sv
// Command bus between the resample phase scheduler and its partners.
// Two independent 4-phase request/acknowledge channels:
//   phase channel   : ph_req / ph_ack carry ph_stream and ph_index to the MAC
//   advance channel : adv_req / adv_ack carry adv_stream to the input buffer
// Modports:
//   master : the scheduler (drives requests and payloads, receives acks)
//   slave  : the MAC / buffer side (receives requests, drives acks)
interface resample_phase_scheduler_if #(
   parameter int L_LOG          = 8,
   parameter int NR_STREAMS_LOG = 4
);
   logic                      ph_req;
   logic                      ph_ack;
   logic [NR_STREAMS_LOG-1:0] ph_stream;
   logic [L_LOG-1:0]          ph_index;
   logic                      adv_req;
   logic                      adv_ack;
   logic [NR_STREAMS_LOG-1:0] adv_stream;

   modport master (
      output ph_req, ph_stream, ph_index, adv_req, adv_stream,
      input  ph_ack, adv_ack
   );

   modport slave (
      input  ph_req, ph_stream, ph_index, adv_req, adv_stream,
      output ph_ack, adv_ack
   );
endinterface

// File: rtl/resample_phase_scheduler.sv
// Sequencer for an L/M polyphase resampler (input buffer -> multiply/accumulate).
// Streams are served round-robin. For each stream's next output sample the
// coefficient phase is sent to the MAC, followed by as many input-advance
// commands to the buffer as that output consumes. Each stream keeps its own
// phase, so streams resample independently.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   en    : run enable, looked at only between output samples
//   bus   : master side of the phase / advance handshake channels
//   busy  : high whenever the sequencer is not idle
module resample_phase_scheduler #(
   parameter int L              = 160,
   parameter int L_LOG          = 8,
   parameter int M              = 147,
   parameter int M_LOG          = 8,
   parameter int NR_STREAMS     = 16,
   parameter int NR_STREAMS_LOG = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   resample_phase_scheduler_if.master        bus,
   output logic                              busy
);

   // Wide enough for (L-1)+M without truncation.
   localparam int ACC_W = L_LOG + M_LOG + 1;

   typedef enum logic [2:0] {
      IDLE, LOAD, PH_REQ, PH_REL, ADV_CHK, ADV_REQ, ADV_REL, NEXT
   } state_t;

   state_t                    state_reg;
   logic [NR_STREAMS_LOG-1:0] s_reg;
   logic [L_LOG-1:0]          phase_reg [NR_STREAMS];
   logic [ACC_W-1:0]          acc_reg;
   logic                      ph_req_reg;
   logic                      adv_req_reg;
   logic [L_LOG-1:0]          ph_index_reg;
   logic [NR_STREAMS_LOG-1:0] ph_stream_reg;
   logic [NR_STREAMS_LOG-1:0] adv_stream_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         s_reg          <= '0;
         acc_reg        <= '0;
         ph_req_reg     <= 1'b0;
         adv_req_reg    <= 1'b0;
         ph_index_reg   <= '0;
         ph_stream_reg  <= '0;
         adv_stream_reg <= '0;
         for (int i = 0; i < NR_STREAMS; i++) begin
            phase_reg[i] <= '0;
         end
      end else begin
         // Requests are a registered decode of the state, so each request
         // trails its state by one clock and drops one clock after leaving it.
         ph_req_reg  <= (state_reg == PH_REQ);
         adv_req_reg <= (state_reg == ADV_REQ);

         case (state_reg)
            IDLE: begin
               if (en) state_reg <= LOAD;
            end
            LOAD: begin
               ph_index_reg   <= phase_reg[s_reg];
               ph_stream_reg  <= s_reg;
               adv_stream_reg <= s_reg;
               acc_reg        <= ACC_W'(phase_reg[s_reg]) + ACC_W'(M);
               state_reg      <= PH_REQ;
            end
            PH_REQ: begin
               // An ack is only taken once our request is actually visible,
               // so a stale or early ack cannot complete a handshake.
               if (ph_req_reg && bus.ph_ack) state_reg <= PH_REL;
            end
            PH_REL: begin
               if (!bus.ph_ack) state_reg <= ADV_CHK;
            end
            ADV_CHK: begin
               if (acc_reg >= ACC_W'(L)) state_reg <= ADV_REQ;
               else                      state_reg <= NEXT;
            end
            ADV_REQ: begin
               if (adv_req_reg && bus.adv_ack) state_reg <= ADV_REL;
            end
            ADV_REL: begin
               if (!bus.adv_ack) begin
                  acc_reg   <= acc_reg - ACC_W'(L);
                  state_reg <= ADV_CHK;
               end
            end
            NEXT: begin
               // acc is below L here, i.e. (p+M) mod L.
               phase_reg[s_reg] <= acc_reg[L_LOG-1:0];
               s_reg <= (s_reg == NR_STREAMS_LOG'(NR_STREAMS - 1)) ? '0 : s_reg + 1'b1;
               state_reg <= en ? LOAD : IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.ph_req     = ph_req_reg;
   assign bus.ph_index   = ph_index_reg;
   assign bus.ph_stream  = ph_stream_reg;
   assign bus.adv_req    = adv_req_reg;
   assign bus.adv_stream = adv_stream_reg;
   assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_resample_phase_scheduler.sv
// Bench for resample_phase_scheduler: one instance with L=160, M=147, four
// streams, and one with L=3, M=7, two streams. Ack responders model the MAC
// and buffer; monitors log each phase command with the advances that follow it.
module tb_resample_phase_scheduler;

   typedef struct { int stream; int index; int advs; } obs_t;
   typedef struct { bit en; int stream; int index; int advs; } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en_a = 1'b0;
   logic en_b = 1'b0;
   logic busy_a, busy_b;

   int checks = 0;
   int errors = 0;
   int dly_a  = 0;
   int cnt_a  = 0;
   int bad_adv_a = 0;
   int bad_adv_b = 0;

   obs_t qa[$];
   obs_t qb[$];
   vec_t tab_a[12];
   vec_t tab_b[6];

   always #5 clk = ~clk;

   resample_phase_scheduler_if #(.L_LOG(8), .NR_STREAMS_LOG(2)) ifa ();
   resample_phase_scheduler_if #(.L_LOG(8), .NR_STREAMS_LOG(1)) ifb ();

   resample_phase_scheduler #(
      .L(160), .L_LOG(8), .M(147), .M_LOG(8), .NR_STREAMS(4), .NR_STREAMS_LOG(2)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .bus(ifa.master), .busy(busy_a)
   );

   resample_phase_scheduler #(
      .L(3), .L_LOG(8), .M(7), .M_LOG(8), .NR_STREAMS(2), .NR_STREAMS_LOG(1)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .bus(ifb.master), .busy(busy_b)
   );

   // Phase ack of instance A can be delayed by dly_a cycles; advance ack is immediate.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifa.ph_ack  <= 1'b0;
         ifa.adv_ack <= 1'b0;
         cnt_a       <= 0;
      end else begin
         ifa.adv_ack <= ifa.adv_req;
         if (ifa.ph_req && !ifa.ph_ack) begin
            if (cnt_a >= dly_a) begin
               ifa.ph_ack <= 1'b1;
               cnt_a      <= 0;
            end else begin
               cnt_a <= cnt_a + 1;
            end
         end else if (!ifa.ph_req) begin
            ifa.ph_ack <= 1'b0;
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifb.ph_ack  <= 1'b0;
         ifb.adv_ack <= 1'b0;
      end else begin
         ifb.ph_ack  <= ifb.ph_req;
         ifb.adv_ack <= ifb.adv_req;
      end
   end

   // Monitors: a rising request starts a new record / adds one advance.
   logic ph_d_a = 1'b0, adv_d_a = 1'b0, ph_d_b = 1'b0, adv_d_b = 1'b0;

   always @(posedge clk) begin
      obs_t t;
      ph_d_a  <= ifa.ph_req;
      adv_d_a <= ifa.adv_req;
      if (ifa.ph_req && !ph_d_a)
         qa.push_back('{int'(ifa.ph_stream), int'(ifa.ph_index), 0});
      if (ifa.adv_req && !adv_d_a) begin
         if (qa.size() == 0) begin
            bad_adv_a++;
         end else begin
            t = qa[qa.size()-1];
            if (int'(ifa.adv_stream) != t.stream) bad_adv_a++;
            t.advs++;
            qa[qa.size()-1] = t;
         end
      end
   end

   always @(posedge clk) begin
      obs_t t;
      ph_d_b  <= ifb.ph_req;
      adv_d_b <= ifb.adv_req;
      if (ifb.ph_req && !ph_d_b)
         qb.push_back('{int'(ifb.ph_stream), int'(ifb.ph_index), 0});
      if (ifb.adv_req && !adv_d_b) begin
         if (qb.size() == 0) begin
            bad_adv_b++;
         end else begin
            t = qb[qb.size()-1];
            if (int'(ifb.adv_stream) != t.stream) bad_adv_b++;
            t.advs++;
            qb[qb.size()-1] = t;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_qa(input int n, input int budget);
      for (int i = 0; i < budget && qa.size() < n; i++) @(negedge clk);
      check("wait_phase_cmd_a", (qa.size() >= n) ? 1 : 0, 1);
   endtask

   task automatic wait_idle_a(input string name);
      for (int i = 0; i < 300 && busy_a; i++) @(negedge clk);
      check(name, int'(busy_a), 0);
   endtask

   initial begin
      int pm[4];
      int bad;
      int advsum;
      int st;

      // Expected sequences, hand-computed.
      // A (L=160, M=147, 4 streams): phases per round 0,147,134; advances 0,1,1.
      for (int i = 0; i < 12; i++) begin
         tab_a[i].en     = 1'b1;
         tab_a[i].stream = i % 4;
         tab_a[i].index  = (i < 4) ? 0 : (i < 8) ? 147 : 134;
         tab_a[i].advs   = (i < 4) ? 0 : 1;
      end
      // B (L=3, M=7, 2 streams): phases 0,1,2 per stream; advances 2,2,3.
      tab_b[0] = '{1'b1, 0, 0, 2};
      tab_b[1] = '{1'b1, 1, 0, 2};
      tab_b[2] = '{1'b1, 0, 1, 2};
      tab_b[3] = '{1'b1, 1, 1, 2};
      tab_b[4] = '{1'b1, 0, 2, 3};
      tab_b[5] = '{1'b1, 1, 2, 3};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ph_req",     int'(ifa.ph_req), 0);
      check("rst_adv_req",    int'(ifa.adv_req), 0);
      check("rst_busy",       int'(busy_a), 0);
      check("rst_ph_index",   int'(ifa.ph_index), 0);
      check("rst_ph_stream",  int'(ifa.ph_stream), 0);
      check("rst_adv_stream", int'(ifa.adv_stream), 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_no_en_busy",   int'(busy_a), 0);
      check("idle_no_en_ph_req", int'(ifa.ph_req), 0);

      // Start latency: en sampled at edge k -> ph_req high after edge k+2.
      en_a = tab_a[0].en;
      @(negedge clk);
      check("lat_k_ph_req", int'(ifa.ph_req), 0);
      check("lat_k_busy",   int'(busy_a), 1);
      @(negedge clk);
      check("lat_k1_ph_req", int'(ifa.ph_req), 0);
      @(negedge clk);
      check("lat_k2_ph_req",   int'(ifa.ph_req), 1);
      check("lat_k2_ph_index", int'(ifa.ph_index), 0);

      // Table: four interleaved streams, stop after the last row.
      for (int i = 0; i < 12; i++) begin
         en_a = tab_a[i].en;
         wait_qa(i + 1, 200);
      end
      en_a = 1'b0;
      wait_idle_a("tab_a_idle");
      check("tab_a_count", qa.size(), 12);
      for (int i = 0; i < 12 && i < qa.size(); i++) begin
         check($sformatf("tab_a[%0d].stream", i), qa[i].stream, tab_a[i].stream);
         check($sformatf("tab_a[%0d].index", i),  qa[i].index,  tab_a[i].index);
         check($sformatf("tab_a[%0d].advs", i),   qa[i].advs,   tab_a[i].advs);
      end

      // Instance B: L=3, M=7, two streams.
      for (int i = 0; i < 6; i++) begin
         en_b = tab_b[i].en;
         for (int j = 0; j < 200 && qb.size() < i + 1; j++) @(negedge clk);
         check("wait_phase_cmd_b", (qb.size() >= i + 1) ? 1 : 0, 1);
      end
      en_b = 1'b0;
      for (int i = 0; i < 300 && busy_b; i++) @(negedge clk);
      check("tab_b_idle",  int'(busy_b), 0);
      check("tab_b_count", qb.size(), 6);
      for (int i = 0; i < 6 && i < qb.size(); i++) begin
         check($sformatf("tab_b[%0d].stream", i), qb[i].stream, tab_b[i].stream);
         check($sformatf("tab_b[%0d].index", i),  qb[i].index,  tab_b[i].index);
         check($sformatf("tab_b[%0d].advs", i),   qb[i].advs,   tab_b[i].advs);
      end
      check("adv_stream_b", bad_adv_b, 0);

      // Full cycle: 160 outputs per stream, 147 advances each, phases return to 0.
      en_a = 1'b1;
      wait_qa(640, 20000);
      en_a = 1'b0;
      wait_idle_a("long_idle");
      check("long_count", qa.size(), 640);
      pm = '{0, 0, 0, 0};
      bad = 0;
      advsum = 0;
      for (int k = 0; k < qa.size(); k++) begin
         st = k % 4;
         if (qa[k].stream != st || qa[k].index != pm[st] ||
             qa[k].advs != (pm[st] + 147) / 160) bad++;
         pm[st] = (pm[st] + 147) % 160;
         advsum += qa[k].advs;
      end
      check("long_seq_bad", bad, 0);
      check("long_adv_sum", advsum, 588);
      en_a = 1'b1;
      wait_qa(641, 200);
      en_a = 1'b0;
      wait_idle_a("wrap_idle");
      if (qa.size() > 640) begin
         check("wrap_stream", qa[640].stream, 0);
         check("wrap_index",  qa[640].index, 0);
      end
      check("adv_stream_a", bad_adv_a, 0);

      // Reset in the middle of an advance handshake.
      en_a = 1'b1;
      for (int i = 0; i < 200 && !ifa.adv_req; i++) @(negedge clk);
      check("mid_adv_req_seen", int'(ifa.adv_req), 1);
      rst = 1'b0;
      #1;
      check("async_adv_req", int'(ifa.adv_req), 0);
      check("async_busy",    int'(busy_a), 0);
      check("async_index",   int'(ifa.ph_index), 0);
      en_a = 1'b0;
      repeat (2) @(negedge clk);
      qa.delete();
      rst = 1'b1;
      @(negedge clk);

      // Restart from stream 0 / phase 0, then stall the phase ack and drop en.
      en_a = 1'b1;
      wait_qa(1, 200);
      if (qa.size() > 0) begin
         check("restart_stream", qa[0].stream, 0);
         check("restart_index",  qa[0].index, 0);
      end
      wait_qa(4, 200);
      dly_a = 10;
      wait_qa(5, 200);
      en_a = 1'b0;
      repeat (4) @(negedge clk);
      check("stall_ph_req", int'(ifa.ph_req), 1);
      check("stall_ph_ack", int'(ifa.ph_ack), 0);
      check("stall_busy",   int'(busy_a), 1);
      wait_idle_a("stall_idle");
      check("stall_count", qa.size(), 5);
      if (qa.size() > 4) begin
         check("stall_stream", qa[4].stream, 0);
         check("stall_index",  qa[4].index, 147);
         check("stall_advs",   qa[4].advs, 1);
      end
      dly_a = 0;
      en_a = 1'b1;
      wait_qa(6, 200);
      en_a = 1'b0;
      wait_idle_a("resume_idle");
      if (qa.size() > 5) begin
         check("resume_stream", qa[5].stream, 1);
         check("resume_index",  qa[5].index, 147);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
